// File: rtl/transmissor_paridade_serial_pkg.sv
// Shared widths, line levels, state encoding and parity helper for the
// 5-bit character link transmitter.
package transmissor_paridade_serial_pkg;

   localparam int LARGURA_CARACTERE = 5;
   localparam int LARGURA_QUADRO    = 6;

   localparam logic LINHA_OCIOSA = 1'b1;
   localparam logic BIT_INICIO   = 1'b0;
   localparam logic BIT_PARADA   = 1'b1;

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      INICIO = 2'd1,
      DADOS  = 2'd2,
      PARADA = 2'd3
   } estado_t;

   // Even-parity bit: makes the XOR of character plus parity equal zero.
   function automatic logic paridade_par(input logic [LARGURA_CARACTERE-1:0] caractere);
      return ^caractere;
   endfunction

endpackage

// File: rtl/transmissor_paridade_serial_if.sv
// Character handshake and frame outputs of the transmitter.
interface transmissor_paridade_serial_if;
   import transmissor_paridade_serial_pkg::*;

   logic [LARGURA_CARACTERE-1:0] caractere_i;
   logic                         valido_i;
   logic                         pronto_o;
   logic                         forcar_erro_i;
   logic [LARGURA_QUADRO-1:0]    quadro_o;
   logic                         serial_o;
   logic                         ocupado_o;
   logic                         fim_o;

   // Character source side.
   modport master (
      output caractere_i, valido_i, forcar_erro_i,
      input  pronto_o, quadro_o, serial_o, ocupado_o, fim_o
   );

   // Transmitter side.
   modport slave (
      input  caractere_i, valido_i, forcar_erro_i,
      output pronto_o, quadro_o, serial_o, ocupado_o, fim_o
   );

endinterface

// File: rtl/transmissor_paridade_serial_gerador_paridade.sv
// Builds the 6-bit frame {caractere, paridade}; forcar_erro flips the parity
// so the far end can be exercised with a deliberately bad frame.
module gerador_paridade
   import transmissor_paridade_serial_pkg::*;
(
   input  logic [LARGURA_CARACTERE-1:0] caractere,
   input  logic                         forcar_erro,
   output logic [LARGURA_QUADRO-1:0]    quadro
);

   // Frame assembly: character on top, parity in the LSB.
   always_comb begin
      quadro = {caractere, paridade_par(caractere) ^ forcar_erro};
   end

endmodule

// File: rtl/transmissor_paridade_serial.sv
// Serial transmitter for the 5-bit character link: accepts a character on
// valid/ready, latches the parity frame and shifts it out as
// start + 6 data bits (MSB first) + stop, each held CICLOS_POR_BIT cycles.
//
// state  | meaning
// OCIOSO | line idle high, ready for a character
// INICIO | start bit (low)
// DADOS  | frame bit quadro[5-indice_bit], indice_bit 0..5
// PARADA | stop bit (high); fim pulses in its last cycle
module transmissor_paridade_serial
   import transmissor_paridade_serial_pkg::*;
#(
   parameter int CICLOS_POR_BIT = 4
)(
   input  logic                          clk,
   input  logic                          rst_n,
   transmissor_paridade_serial_if.slave  bus
);

   localparam int LARG_CONT = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
   localparam logic [LARG_CONT-1:0] ULTIMO_CICLO = LARG_CONT'(CICLOS_POR_BIT - 1);
   localparam logic [2:0]           ULTIMO_BIT   = 3'(LARGURA_QUADRO - 1);

   estado_t                   estado, estado_prox;
   logic [LARG_CONT-1:0]      contador_ciclos, contador_prox;
   logic [2:0]                indice_bit, indice_prox;
   logic [LARGURA_QUADRO-1:0] quadro_q, quadro_prox;
   logic [LARGURA_QUADRO-1:0] quadro_gerado;
   logic                      serial_q, serial_prox;
   logic                      pronto_q, pronto_prox;
   logic                      ocupado_q, ocupado_prox;
   logic                      fim_q, fim_prox;
   logic                      fim_de_bit;
   logic [2:0]                pos_bit;

   gerador_paridade u_gerador_paridade (
      .caractere   (bus.caractere_i),
      .forcar_erro (bus.forcar_erro_i),
      .quadro      (quadro_gerado)
   );

   // State, counters and registered outputs; reset forces the line idle at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado          <= OCIOSO;
         contador_ciclos <= '0;
         indice_bit      <= '0;
         quadro_q        <= '0;
         serial_q        <= LINHA_OCIOSA;
         pronto_q        <= 1'b1;
         ocupado_q       <= 1'b0;
         fim_q           <= 1'b0;
      end else begin
         estado          <= estado_prox;
         contador_ciclos <= contador_prox;
         indice_bit      <= indice_prox;
         quadro_q        <= quadro_prox;
         serial_q        <= serial_prox;
         pronto_q        <= pronto_prox;
         ocupado_q       <= ocupado_prox;
         fim_q           <= fim_prox;
      end
   end

   // Next state and next output values; outputs are derived from the next
   // state so every output register lines up with the state it describes.
   always_comb begin
      estado_prox   = estado;
      contador_prox = contador_ciclos;
      indice_prox   = indice_bit;
      quadro_prox   = quadro_q;
      fim_de_bit    = (contador_ciclos == ULTIMO_CICLO);

      unique case (estado)
         OCIOSO: begin
            contador_prox = '0;
            if (bus.valido_i && pronto_q) begin
               quadro_prox = quadro_gerado;
               estado_prox = INICIO;
            end
         end
         INICIO: begin
            if (fim_de_bit) begin
               contador_prox = '0;
               indice_prox   = '0;
               estado_prox   = DADOS;
            end else begin
               contador_prox = contador_ciclos + 1'b1;
            end
         end
         DADOS: begin
            if (fim_de_bit) begin
               contador_prox = '0;
               if (indice_bit == ULTIMO_BIT) begin
                  estado_prox = PARADA;
               end else begin
                  indice_prox = indice_bit + 3'd1;
               end
            end else begin
               contador_prox = contador_ciclos + 1'b1;
            end
         end
         PARADA: begin
            if (fim_de_bit) begin
               contador_prox = '0;
               estado_prox   = OCIOSO;
            end else begin
               contador_prox = contador_ciclos + 1'b1;
            end
         end
         default: estado_prox = OCIOSO;
      endcase

      pos_bit      = ULTIMO_BIT - indice_prox;
      pronto_prox  = (estado_prox == OCIOSO);
      ocupado_prox = (estado_prox != OCIOSO);
      fim_prox     = (estado_prox == PARADA) && (contador_prox == ULTIMO_CICLO);

      unique case (estado_prox)
         INICIO:  serial_prox = BIT_INICIO;
         DADOS:   serial_prox = quadro_prox[pos_bit];
         PARADA:  serial_prox = BIT_PARADA;
         default: serial_prox = LINHA_OCIOSA;
      endcase
   end

   assign bus.quadro_o  = quadro_q;
   assign bus.serial_o  = serial_q;
   assign bus.pronto_o  = pronto_q;
   assign bus.ocupado_o = ocupado_q;
   assign bus.fim_o     = fim_q;

endmodule

// File: tb/tb_transmissor_paridade_serial.sv
// Directed bench: one transmitter at 4 cycles/bit, one at 1 cycle/bit.
module tb_transmissor_paridade_serial;

   logic clk = 1'b0;
   logic rst_n4;
   logic rst_n1;
   int   tests = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   transmissor_paridade_serial_if bus4 ();
   transmissor_paridade_serial_if bus1 ();

   transmissor_paridade_serial #(.CICLOS_POR_BIT(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n4),
      .bus   (bus4)
   );

   transmissor_paridade_serial #(.CICLOS_POR_BIT(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n1),
      .bus   (bus1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Walks a whole frame starting at the first cycle after acceptance, then
   // checks the idle cycle that follows the stop bit.
   task automatic verifica(input int sel, input int cpb, input logic [5:0] q, input string tag);
      logic [7:0] seq;
      logic s, f, p, o;
      logic [5:0] qd;
      seq = {1'b0, q, 1'b1};
      for (int k = 0; k < 8 * cpb; k++) begin
         @(negedge clk);
         if (sel == 0) begin
            s = bus4.serial_o; f = bus4.fim_o; p = bus4.pronto_o; o = bus4.ocupado_o; qd = bus4.quadro_o;
         end else begin
            s = bus1.serial_o; f = bus1.fim_o; p = bus1.pronto_o; o = bus1.ocupado_o; qd = bus1.quadro_o;
         end
         chk($sformatf("%s_serial_c%0d", tag, k + 1), s, seq[7 - k / cpb]);
         chk($sformatf("%s_fim_c%0d", tag, k + 1), f, (k == 8 * cpb - 1));
         chk($sformatf("%s_pronto_c%0d", tag, k + 1), p, 0);
         chk($sformatf("%s_ocupado_c%0d", tag, k + 1), o, 1);
         if (k == 0) chk({tag, "_quadro"}, qd, q);
      end
      @(negedge clk);
      if (sel == 0) begin
         s = bus4.serial_o; f = bus4.fim_o; p = bus4.pronto_o; o = bus4.ocupado_o;
      end else begin
         s = bus1.serial_o; f = bus1.fim_o; p = bus1.pronto_o; o = bus1.ocupado_o;
      end
      chk({tag, "_idle_pronto"}, p, 1);
      chk({tag, "_idle_ocupado"}, o, 0);
      chk({tag, "_idle_serial"}, s, 1);
      chk({tag, "_idle_fim"}, f, 0);
   endtask

   // Far-end receiver model for the 4 cycles/bit transmitter: samples the
   // middle of every bit and compares against an independently built frame.
   task automatic receber(input logic [4:0] c, input logic fe, input int n);
      logic [5:0] rx;
      logic [5:0] esperado;
      logic got;
      logic pr;
      esperado = {c, (^c) ^ fe};
      @(negedge clk);
      bus4.caractere_i = c; bus4.forcar_erro_i = fe; bus4.valido_i = 1'b1;
      @(posedge clk);
      #1 bus4.valido_i = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (bus4.serial_o == 1'b0) got = 1'b1;
      end
      chk($sformatf("rx%0d_start_seen", n), got, 1);
      if (got) begin
         @(negedge clk);
         chk($sformatf("rx%0d_start_mid", n), bus4.serial_o, 0);
         for (int b = 0; b < 6; b++) begin
            repeat (4) @(negedge clk);
            rx[5 - b] = bus4.serial_o;
         end
         repeat (4) @(negedge clk);
         chk($sformatf("rx%0d_stop", n), bus4.serial_o, 1);
         chk($sformatf("rx%0d_vs_quadro", n), rx, bus4.quadro_o);
         chk($sformatf("rx%0d_vs_model", n), rx, esperado);
         if (!fe) chk($sformatf("rx%0d_even", n), ^rx, 0);
         pr = 1'b0;
         for (int t = 0; t < 10 && !pr; t++) begin
            @(negedge clk);
            if (bus4.pronto_o) pr = 1'b1;
         end
         chk($sformatf("rx%0d_pronto", n), pr, 1);
      end
   endtask

   initial begin
      rst_n4 = 1'b0;
      rst_n1 = 1'b0;
      bus4.caractere_i = '0; bus4.valido_i = 1'b0; bus4.forcar_erro_i = 1'b0;
      bus1.caractere_i = '0; bus1.valido_i = 1'b0; bus1.forcar_erro_i = 1'b0;
      #12;
      chk("rst_serial", bus4.serial_o, 1);
      chk("rst_pronto", bus4.pronto_o, 1);
      chk("rst_ocupado", bus4.ocupado_o, 0);
      chk("rst_fim", bus4.fim_o, 0);
      chk("rst_quadro", bus4.quadro_o, 6'b000000);
      chk("rst1_serial", bus1.serial_o, 1);
      chk("rst1_pronto", bus1.pronto_o, 1);
      @(negedge clk);
      rst_n4 = 1'b1;
      rst_n1 = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_pronto", bus4.pronto_o, 1);
      chk("post_rst_serial", bus4.serial_o, 1);

      // Plan 1: 10110 -> 101101
      @(negedge clk);
      bus4.caractere_i = 5'b10110; bus4.forcar_erro_i = 1'b0; bus4.valido_i = 1'b1;
      @(posedge clk);
      #1 bus4.valido_i = 1'b0;
      verifica(0, 4, 6'b101101, "t1");
      repeat (3) @(negedge clk);
      chk("t1_quadro_hold", bus4.quadro_o, 6'b101101);

      // Plan 2: forced parity error, then clean
      @(negedge clk);
      bus4.caractere_i = 5'b00000; bus4.forcar_erro_i = 1'b1; bus4.valido_i = 1'b1;
      @(posedge clk);
      #1 bus4.valido_i = 1'b0; bus4.forcar_erro_i = 1'b0;
      verifica(0, 4, 6'b000001, "t2e");
      chk("t2e_far_end_flags", ^bus4.quadro_o, 1);
      @(negedge clk);
      bus4.caractere_i = 5'b00000; bus4.forcar_erro_i = 1'b0; bus4.valido_i = 1'b1;
      @(posedge clk);
      #1 bus4.valido_i = 1'b0; bus4.forcar_erro_i = 1'b1;
      verifica(0, 4, 6'b000000, "t2ok");
      bus4.forcar_erro_i = 1'b0;

      // Plan 3: valido held, char changes mid-frame, back-to-back frames
      @(negedge clk);
      bus4.caractere_i = 5'b11111; bus4.valido_i = 1'b1;
      @(posedge clk);
      #1 bus4.caractere_i = 5'b00001;
      verifica(0, 4, 6'b111111, "t3a");
      @(posedge clk);
      #1 bus4.valido_i = 1'b0;
      verifica(0, 4, 6'b000011, "t3b");

      // Plan 4: async reset during data bit 3, then a clean frame
      @(negedge clk);
      bus4.caractere_i = 5'b11100; bus4.valido_i = 1'b1;
      @(posedge clk);
      #1 bus4.valido_i = 1'b0;
      repeat (18) @(negedge clk);
      chk("t4_bit3_before_rst", bus4.serial_o, 0);
      chk("t4_busy_before_rst", bus4.ocupado_o, 1);
      #2 rst_n4 = 1'b0;
      #1;
      chk("t4_rst_serial", bus4.serial_o, 1);
      chk("t4_rst_pronto", bus4.pronto_o, 1);
      chk("t4_rst_ocupado", bus4.ocupado_o, 0);
      chk("t4_rst_fim", bus4.fim_o, 0);
      repeat (2) begin
         @(negedge clk);
         chk("t4_rst_hold_fim", bus4.fim_o, 0);
      end
      rst_n4 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t4_idle_serial", bus4.serial_o, 1);
         chk("t4_idle_fim", bus4.fim_o, 0);
         chk("t4_idle_pronto", bus4.pronto_o, 1);
      end
      bus4.caractere_i = 5'b01010; bus4.valido_i = 1'b1;
      @(posedge clk);
      #1 bus4.valido_i = 1'b0;
      verifica(0, 4, 6'b010100, "t4n");

      // Plan 5: one cycle per bit, 11001 -> 110011
      @(negedge clk);
      bus1.caractere_i = 5'b11001; bus1.valido_i = 1'b1;
      @(posedge clk);
      #1 bus1.valido_i = 1'b0;
      verifica(1, 1, 6'b110011, "t5");

      // Plan 6: random characters through the receiver model
      for (int n = 0; n < 200; n++) begin
         receber(5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0), n);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/transmissor_paridade_serial.md
Name: transmissor_paridade_serial

Overview:
Transmit side of the 5-bit character link. It accepts a 5-bit character with a valid/ready handshake and appends an even-parity bit to form a 6-bit frame {caractere[4:0], paridade}. It exposes the frame in parallel and also shifts it out as a UART-style serial frame (start, 6 data bits, stop). The far end checks the frame's parity and drives the 7-segment display.

Parameters:
CICLOS_POR_BIT, 4, clock cycles each serial bit is held; legal range ≥1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
caractere_i  input  5  character to send
valido_i  input  1  caractere_i is valid
pronto_o  output  1  ready to accept a character
forcar_erro_i  input  1  sampled at acceptance; inverts the parity bit (test hook)
quadro_o  output  6  last accepted frame {caractere, paridade}
serial_o  output  1  serial line; idle high
ocupado_o  output  1  frame in flight
fim_o  output  1  one-cycle pulse in the last cycle of the stop bit

Behaviour:
- Reset is asynchronous and active-low on rst_n; single clock clk. Reset values: state OCIOSO, serial_o=1, pronto_o=1, ocupado_o=0, fim_o=0, quadro_o=0, all counters 0.
- Parity: paridade = ^caractere_i XOR forcar_erro_i. With forcar_erro_i=0, ^quadro_o == 0 (even parity).
- Acceptance: the block accepts on a rising edge where valido_i && pronto_o. On that edge:
  - quadro_o <= {caractere_i, paridade}
  - state -> INICIO
  - pronto_o <= 0, ocupado_o <= 1
- Inputs change after acceptance: changes to caractere_i or forcar_erro_i are ignored. valido_i while pronto_o=0 is ignored; no queueing.
- States and serial_o:
  - OCIOSO: serial_o=1.
  - INICIO: serial_o=0 for CICLOS_POR_BIT cycles, then DADOS.
  - DADOS: serial_o=quadro_o[5-indice_bit], indice_bit 0..5, so the order is caractere[4] first and paridade last. Each bit is held CICLOS_POR_BIT cycles. After bit 5 the state moves to PARADA.
  - PARADA: serial_o=1 for CICLOS_POR_BIT cycles. fim_o=1 in the final cycle only. On the next edge: state -> OCIOSO, pronto_o=1, ocupado_o=0.
- Counters: contador_ciclos counts 0..CICLOS_POR_BIT-1 and wraps to 0 on each bit boundary. indice_bit is 3 bits; it is cleared on entering DADOS and never exceeds 5.
- Outputs are registered; serial_o carries no combinational path from inputs.
- Timing:
  - Start bit appears on the cycle after the acceptance edge.
  - Frame length is 8*CICLOS_POR_BIT cycles.
  - Acceptance to pronto_o=1 takes 8*CICLOS_POR_BIT cycles.
  - Back-to-back: a new character may be accepted on the first cycle pronto_o=1. Maximum throughput is one frame per 8*CICLOS_POR_BIT+1 cycles.
- CICLOS_POR_BIT=1: every bit lasts exactly one cycle; same state sequence, no special case.
- Reset mid-frame: serial_o goes to 1 immediately and asynchronously, the frame is abandoned, and fim_o is not pulsed. After rst_n deasserts, the block sits in OCIOSO.
- quadro_o holds its value until the next acceptance and stays valid while idle.

Decomposition:
- Shared package contents:
  - LARGURA_CARACTERE=5, LARGURA_QUADRO=6
  - state encoding OCIOSO/INICIO/DADOS/PARADA (2 bits)
  - LINHA_OCIOSA=1'b1, BIT_INICIO=1'b0, BIT_PARADA=1'b1
  - parity function (XOR reduction)
- Sub-module: gerador_paridade, combinational, 5-bit char + forcar_erro -> 6-bit frame. The receiver-side checker can share it in bench models.
- The FSM and counters stay in the top module.

Test Plan:
1. CICLOS_POR_BIT=4, caractere_i=5'b10110, valido_i pulsed in idle -> quadro_o=6'b101101. serial_o over 32 cycles is 0,1,0,1,1,0,1,1, each held 4 cycles. fim_o is high in cycle 32 only; pronto_o=1 at cycle 33.
2. caractere_i=5'b00000, forcar_erro_i=1 -> quadro_o=6'b000001; the parity check at the far end flags an error. Same char with forcar_erro_i=0 -> quadro_o=6'b000000.
3. valido_i held high with caractere_i=5'b11111 then 5'b00001 -> two frames, 6'b111111 then 6'b000011. There is exactly one idle cycle between the stop bit and the next start bit. caractere_i changing mid-frame does not alter serial_o.
4. rst_n pulled low during DADOS bit 3 (asynchronously, mid-cycle) -> serial_o=1 and pronto_o=1 immediately, with no fim_o. After release, a new frame 5'b01010 -> 6'b010100 transmits correctly.
5. CICLOS_POR_BIT=1, caractere_i=5'b11001 -> serial_o sequence 0,1,1,0,0,1,1,1 over 8 cycles; fim_o on cycle 8.
6. Random 200 characters through a bench receiver model -> every decoded 6-bit frame matches quadro_o, and parity is even whenever forcar_erro_i=0.
